int_push_controller: RTL and testbench
======================================

Name: int_push_controller

Overview:
- Multi-cycle hardware interrupt sequencer. It drains the pipeline, then pushes the flags and both PC halves onto the stack, one segment per cycle, and finally loads the PC from the interrupt vector.
- Sits in the control unit beside the RTI pop sequencer. It drives the stack-push segment select and the PC-source controls of the memory and write-back stages.

Parameters:
- DRAIN_CYCLES, 2, number of stall cycles before the first push (pipeline flush depth); legal range 1..7.
- SEG_W, 2, width of the push_segment select.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- int_req  in  1  external interrupt line; the request is its rising edge.
- rti_busy  in  1  high while the RTI pop sequencer is active.
- imm  in  1  the instruction currently in decode is a two-word immediate instruction.
- stall  out  1  freeze fetch/decode and insert bubbles.
- int_push  out  1  stack-push enable to the memory stage (SP decrements per push).
- push_segment  out  SEG_W  word to push: 00 flags, 01 PC high, 10 PC low, 11 none.
- pc_adjust  out  1  saved PC skips the immediate word (datapath pushes PC+1).
- load_vector  out  1  write PC from the interrupt vector location.
- int_ack  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: rst low at any time, including mid-sequence, forces IDLE immediately. Cleared on reset: pending, imm_seen, drain counter, int_req_d. Outputs on reset: stall=0, int_push=0, push_segment=11, pc_adjust=0, load_vector=0, int_ack=0.
- Edge detect: int_req_d is registered each cycle. An edge is int_req & ~int_req_d, and sets pending. A level held high never generates a second request.
- All state and registers update on the clk rising edge. Outputs are pure decodes of the state register (Moore), so they change one cycle after the transition condition is sampled.
- State IDLE: all outputs at reset values.
  - Leave IDLE when (pending or edge) and ~rti_busy; go to DRAIN, load counter = DRAIN_CYCLES-1, clear pending.
  - If rti_busy is high, the request stays pending and IDLE holds.
- State DRAIN: stall=1.
  - The counter decrements each cycle; at 0, go to PUSH_F.
  - imm sampled high in any DRAIN cycle sets imm_seen.
  - Occupancy is exactly DRAIN_CYCLES cycles.
- State PUSH_F: stall=1, int_push=1, push_segment=00.
- State PUSH_PH: stall=1, int_push=1, push_segment=01, pc_adjust=imm_seen.
- State PUSH_PL: stall=1, int_push=1, push_segment=10, pc_adjust=imm_seen.
- State LOAD: stall=1, load_vector=1, push_segment=11.
- State ACK: stall=0, int_ack=1. Clears imm_seen. Next state is IDLE.
- Sequence order is fixed: PUSH_F → PUSH_PH → PUSH_PL → LOAD → ACK, one cycle each, unconditional.
- Total latency from the sampled edge to int_ack: DRAIN_CYCLES+5 cycles. With the default this is 7.
- A new edge during the sequence sets pending (one-deep; further edges are merged). It is serviced after ACK→IDLE, with a minimum of one IDLE cycle between sequences.
- rti_busy is ignored once the sequence has left IDLE.
- Push order is the exact inverse of the RTI pop order: PC low, then PC high, then flags are popped.
- Illegal state encodings recover to IDLE with reset output values.

Decomposition:
- Shared control package holds:
  - state encoding localparams (3-bit: IDLE, DRAIN, PUSH_F, PUSH_PH, PUSH_PL, LOAD, ACK);
  - segment codes SEG_FLAGS=00, SEG_PCH=01, SEG_PCL=10, SEG_NONE=11, shared with the RTI pop sequencer.
- One natural sub-module: int_edge_latch (edge detect + one-deep pending bit, clear input). Everything else stays in one FSM.

Test Plan:
- Reset/idle: hold rst low 3 cycles, release, int_req=0 → all outputs at reset values (push_segment=11) for 10 cycles.
- Basic sequence: int_req pulse sampled at cycle 0, DRAIN_CYCLES=2, imm=0 →
  - stall=1 on cycles 1–6;
  - int_push=1 with push_segment 00,01,10 on cycles 3,4,5;
  - load_vector=1 on cycle 6;
  - int_ack=1 on cycle 7;
  - pc_adjust=0 throughout.
- Immediate adjust: same as basic sequence, with imm=1 on cycle 1 only → pc_adjust=1 on cycles 4–5 only. A following interrupt without imm → pc_adjust=0.
- RTI interlock: rti_busy=1 for cycles 0–4, edge at cycle 1 → stays IDLE through cycle 5; stall rises at cycle 6 and the full sequence follows.
- Pending/level: int_req held high for 20 cycles → exactly one int_ack. A second edge at cycle 3 → a second sequence starts with DRAIN on cycle 9, and the pending bit is cleared.
- Reset mid-sequence: rst low asynchronously during PUSH_PH → outputs return to reset values before the next clk edge. After release the FSM sits in IDLE with pending=0.

Source files
------------

// File: rtl/int_push_controller_pkg.sv
// Shared control definitions for the interrupt push sequencer: state
// encodings, stack segment codes (common with the RTI pop sequencer) and
// the output decode used by the FSM.
package int_push_controller_pkg;

  // 3-bit state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_PUSH_F  = 3'd2;
  localparam logic [2:0] ST_PUSH_PH = 3'd3;
  localparam logic [2:0] ST_PUSH_PL = 3'd4;
  localparam logic [2:0] ST_LOAD    = 3'd5;
  localparam logic [2:0] ST_ACK     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_DRAIN   = ST_DRAIN,
    S_PUSH_F  = ST_PUSH_F,
    S_PUSH_PH = ST_PUSH_PH,
    S_PUSH_PL = ST_PUSH_PL,
    S_LOAD    = ST_LOAD,
    S_ACK     = ST_ACK
  } state_e;

  // Stack segment codes, shared with the RTI pop sequencer
  localparam logic [1:0] SEG_FLAGS = 2'b00;
  localparam logic [1:0] SEG_PCH   = 2'b01;
  localparam logic [1:0] SEG_PCL   = 2'b10;
  localparam logic [1:0] SEG_NONE  = 2'b11;

  typedef struct packed {
    logic       stall;
    logic       int_push;
    logic [1:0] segment;
    logic       pc_adjust;
    logic       load_vector;
    logic       int_ack;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RESET = '{
    stall:       1'b0,
    int_push:    1'b0,
    segment:     SEG_NONE,
    pc_adjust:   1'b0,
    load_vector: 1'b0,
    int_ack:     1'b0
  };

  // Moore output decode for a given state; unknown encodings give reset values
  function automatic ctrl_out_t decode_ctrl(input state_e st, input logic imm_seen);
    ctrl_out_t o;
    o = CTRL_RESET;
    case (st)
      S_IDLE: begin
        o = CTRL_RESET;
      end
      S_DRAIN: begin
        o.stall = 1'b1;
      end
      S_PUSH_F: begin
        o.stall    = 1'b1;
        o.int_push = 1'b1;
        o.segment  = SEG_FLAGS;
      end
      S_PUSH_PH: begin
        o.stall     = 1'b1;
        o.int_push  = 1'b1;
        o.segment   = SEG_PCH;
        o.pc_adjust = imm_seen;
      end
      S_PUSH_PL: begin
        o.stall     = 1'b1;
        o.int_push  = 1'b1;
        o.segment   = SEG_PCL;
        o.pc_adjust = imm_seen;
      end
      S_LOAD: begin
        o.stall       = 1'b1;
        o.load_vector = 1'b1;
        o.segment     = SEG_NONE;
      end
      S_ACK: begin
        o.int_ack = 1'b1;
      end
      default: begin
        o = CTRL_RESET;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/int_push_controller_if.sv
// Interrupt request / stack-push control bundle between the control unit
// environment (master) and the interrupt push sequencer (slave).
interface int_push_controller_if #(
  parameter int SEG_W = 2
) ();
  logic             int_req;
  logic             rti_busy;
  logic             imm;
  logic             stall;
  logic             int_push;
  logic [SEG_W-1:0] push_segment;
  logic             pc_adjust;
  logic             load_vector;
  logic             int_ack;

  modport master (
    output int_req, rti_busy, imm,
    input  stall, int_push, push_segment, pc_adjust, load_vector, int_ack
  );

  modport slave (
    input  int_req, rti_busy, imm,
    output stall, int_push, push_segment, pc_adjust, load_vector, int_ack
  );
endinterface

// File: rtl/int_push_controller_edge_latch.sv
// Rising-edge detector on the interrupt line with a one-deep pending bit.
// Further edges while pending merge into the same request; i_clear consumes
// both the stored request and any edge seen in the same cycle.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_int_req,
  input  logic i_clear,
  output logic o_edge,
  output logic o_pending
);

  logic r_int_req_d;
  logic r_pending;

  assign o_edge    = i_int_req & ~r_int_req_d;
  assign o_pending = r_pending;

  // Delay the request line and maintain the pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_req_d <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_int_req_d <= i_int_req;
      if (i_clear) begin
        r_pending <= 1'b0;
      end else if (o_edge) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

endmodule

// File: rtl/int_push_controller.sv
// Hardware interrupt sequencer: drains the pipeline, pushes flags, PC high
// and PC low (inverse of the RTI pop order), loads the PC from the vector
// and acknowledges. Outputs are registered decodes of the next state, so
// they always reflect the current state register.
module int_push_controller
  import int_push_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int SEG_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  int_push_controller_if.slave bus
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_e    r_state;
  state_e    w_state_nxt;
  logic [2:0] r_drain_cnt;
  logic [2:0] w_drain_cnt_nxt;
  logic      r_imm_seen;
  logic      w_imm_seen_nxt;
  ctrl_out_t r_ctrl;
  ctrl_out_t w_ctrl_nxt;
  logic      w_edge;
  logic      w_pending;
  logic      w_clear;

  int_edge_latch u_edge_latch (
    .clk       (clk),
    .rst       (rst),
    .i_int_req (bus.int_req),
    .i_clear   (w_clear),
    .o_edge    (w_edge),
    .o_pending (w_pending)
  );

  // Next-state, drain counter and immediate-tracking logic
  always_comb begin
    w_state_nxt     = S_IDLE;
    w_drain_cnt_nxt = r_drain_cnt;
    w_imm_seen_nxt  = r_imm_seen;
    w_clear         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_pending | w_edge) && !bus.rti_busy) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = DRAIN_LOAD;
          w_clear         = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_imm_seen_nxt = r_imm_seen | bus.imm;
        if (r_drain_cnt == 3'd0) begin
          w_state_nxt = S_PUSH_F;
        end else begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = r_drain_cnt - 3'd1;
        end
      end
      S_PUSH_F:  w_state_nxt = S_PUSH_PH;
      S_PUSH_PH: w_state_nxt = S_PUSH_PL;
      S_PUSH_PL: w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_ACK;
      S_ACK: begin
        w_state_nxt    = S_IDLE;
        w_imm_seen_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_drain_cnt_nxt = 3'd0;
        w_imm_seen_nxt  = 1'b0;
      end
    endcase
    w_ctrl_nxt = decode_ctrl(w_state_nxt, w_imm_seen_nxt);
  end

  // Sequencer state and registered output decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 3'd0;
      r_imm_seen  <= 1'b0;
      r_ctrl      <= CTRL_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_imm_seen  <= w_imm_seen_nxt;
      r_ctrl      <= w_ctrl_nxt;
    end
  end

  assign bus.stall        = r_ctrl.stall;
  assign bus.int_push     = r_ctrl.int_push;
  assign bus.push_segment = SEG_W'(r_ctrl.segment);
  assign bus.pc_adjust    = r_ctrl.pc_adjust;
  assign bus.load_vector  = r_ctrl.load_vector;
  assign bus.int_ack      = r_ctrl.int_ack;

endmodule

// File: tb/tb_int_push_controller.sv
// Scoreboard bench for int_push_controller: each interrupt stimulus queues
// the expected per-cycle output vectors; a negedge monitor compares every
// cycle against the queue head, or against idle outputs when nothing is due.
module tb_int_push_controller;

  localparam int D = 2;
  // Vector layout: {stall, int_push, push_segment[1:0], pc_adjust, load_vector, int_ack}
  localparam logic [6:0] V_IDLE = 7'b0_0_11_0_0_0;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  int   c0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [6:0] mon_want;

  int_push_controller_if #(.SEG_W(2)) bus ();

  int_push_controller #(.DRAIN_CYCLES(D), .SEG_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] obs();
    return {bus.stall, bus.int_push, bus.push_segment, bus.pc_adjust, bus.load_vector, bus.int_ack};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue expected outputs for a sequence whose IDLE exit is sampled at end of cycle s
  task automatic push_seq(input int s, input logic adj);
    for (int k = 1; k <= D + 5; k++) begin
      exp_t e;
      e.cyc = s + k;
      if (k <= D)          e.v = 7'b1_0_11_0_0_0;
      else if (k == D + 1) e.v = 7'b1_1_00_0_0_0;
      else if (k == D + 2) e.v = {1'b1, 1'b1, 2'b01, adj, 1'b0, 1'b0};
      else if (k == D + 3) e.v = {1'b1, 1'b1, 2'b10, adj, 1'b0, 1'b0};
      else if (k == D + 4) e.v = 7'b1_0_11_0_1_0;
      else                 e.v = 7'b0_0_11_0_0_1;
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle output monitor against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      mon_want = V_IDLE;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e    = exp_q.pop_front();
        mon_want = mon_e.v;
      end
      check("out", obs(), mon_want);
    end
  end

  initial begin
    bus.int_req  = 1'b0;
    bus.rti_busy = 1'b0;
    bus.imm      = 1'b0;
    rst          = 1'b0;

    // Reset and idle
    step(3);
    check("rst", obs(), V_IDLE);
    rst    = 1'b1;
    mon_en = 1'b1;
    step(10);

    // Basic sequence
    bus.int_req = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b0);
    step();
    bus.int_req = 1'b0;
    step(10);

    // Immediate adjust: imm high on first DRAIN cycle only
    bus.int_req = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b1);
    step();
    bus.int_req = 1'b0;
    bus.imm     = 1'b1;
    step();
    bus.imm = 1'b0;
    step(10);

    // Following interrupt, imm only while still IDLE -> no adjust
    bus.int_req = 1'b1;
    bus.imm     = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b0);
    step();
    bus.int_req = 1'b0;
    bus.imm     = 1'b0;
    step(10);

    // RTI interlock: busy cycles 0..4, edge at cycle 1
    bus.rti_busy = 1'b1;
    c0 = cyc;
    step();
    bus.int_req = 1'b1;
    push_seq(c0 + 5, 1'b0);
    step();
    bus.int_req = 1'b0;
    step(3);
    bus.rti_busy = 1'b0;
    step(12);

    // Level held high for 20 cycles -> single sequence
    bus.int_req = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b0);
    step(20);
    bus.int_req = 1'b0;
    step(5);

    // Second edge at cycle 3 -> pending, second DRAIN on cycle 9
    bus.int_req = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b0);
    push_seq(c0 + 8, 1'b0);
    step();
    bus.int_req = 1'b0;
    step(2);
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    step(20);

    // Reset in PUSH_PH with a request pending
    bus.int_req = 1'b1;
    c0 = cyc;
    push_seq(c0, 1'b0);
    step();
    bus.int_req = 1'b0;
    step();
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    step();
    mon_en = 1'b0;
    exp_q.delete();
    check("ph", obs(), 7'b1_1_01_0_0_0);
    #2;
    rst = 1'b0;
    #1;
    check("async", obs(), V_IDLE);
    step(2);
    rst    = 1'b1;
    mon_en = 1'b1;
    step(15);
    mon_en = 1'b0;

    check("qempty", 7'(exp_q.size()), 7'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
